// File: rtl/dp_pkg.sv
// Shared types and flag bit positions for the self-sequencing datapath core.
package dp_pkg;

  typedef enum logic [1:0] {
    CMD_REG  = 2'b00,
    CMD_IMM  = 2'b01,
    CMD_MOVI = 2'b10,
    CMD_MOVR = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_MVN = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SH_NONE = 2'b00,
    SH_LSL1 = 2'b01,
    SH_LSR1 = 2'b10,
    SH_ASR1 = 2'b11
  } shift_t;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RDA  = 3'd1,
    S_RDB  = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam int FLAG_Z = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/dp_seq_core_if.sv
// Command handshake plus result/status/debug bus between controller (master) and core (slave).
interface dp_seq_core_if #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
);
  import dp_pkg::*;

  localparam int RW = $clog2(NREGS);

  logic                   cmd_valid;
  logic                   cmd_ready;
  cmd_op_t                cmd_op;
  alu_op_t                alu_op;
  shift_t                 shift;
  logic [RW-1:0]          rd;
  logic [RW-1:0]          rn;
  logic [RW-1:0]          rm;
  logic [WIDTH-1:0]       imm;
  logic                   wb_en;
  logic                   set_flags;
  logic                   done;
  logic [WIDTH-1:0]       result;
  logic [3:0]             status_out;
  logic [NREGS*WIDTH-1:0] reg_out;

  modport master (
    output cmd_valid, cmd_op, alu_op, shift, rd, rn, rm, imm, wb_en, set_flags,
    input  cmd_ready, done, result, status_out, reg_out
  );

  modport slave (
    input  cmd_valid, cmd_op, alu_op, shift, rd, rn, rm, imm, wb_en, set_flags,
    output cmd_ready, done, result, status_out, reg_out
  );

endinterface

// File: rtl/dp_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port, async clear, flat debug view.
module dp_regfile #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input  logic                       clk,
  input  logic                       rst_n_i,
  input  logic                       we_i,
  input  logic [$clog2(NREGS)-1:0]   waddr_i,
  input  logic [WIDTH-1:0]           wdata_i,
  input  logic [$clog2(NREGS)-1:0]   raddr_a_i,
  input  logic [$clog2(NREGS)-1:0]   raddr_b_i,
  output logic [WIDTH-1:0]           rdata_a_o,
  output logic [WIDTH-1:0]           rdata_b_o,
  output logic [NREGS*WIDTH-1:0]     reg_out_o
);

  logic [WIDTH-1:0] mem_q [NREGS];

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int i = 0; i < NREGS; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign reg_out_o[g*WIDTH +: WIDTH] = mem_q[g];
  end

endmodule

// File: rtl/dp_seq_core.sv
// Self-sequencing datapath: accepts one command per handshake and walks RDA/RDB/EXEC/WB internally.
module dp_seq_core
  import dp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int NREGS = 8
) (
  input logic            clk,
  input logic            reset_n,
  dp_seq_core_if.slave   bus
);

  localparam int RW = $clog2(NREGS);
  localparam int MSB = WIDTH - 1;

  state_t           state_q;
  cmd_op_t          cmd_op_q;
  alu_op_t          alu_op_q;
  shift_t           shift_q;
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic [WIDTH-1:0] imm_q;
  logic             wb_en_q, set_flags_q;
  logic [WIDTH-1:0] a_q, b_q, c_q;
  logic [3:0]       status_q;
  logic             done_q, ready_q;

  logic [WIDTH-1:0] ra_dat, rb_dat, shift_dat, alu_dat;
  logic [WIDTH:0]   sum_w;
  logic             alu_c, alu_v;
  alu_op_t          eff_op;
  logic             wr_en;
  logic [WIDTH-1:0] wr_dat;

  assign wr_en  = (state_q == S_WB) && wb_en_q;
  assign wr_dat = (cmd_op_q == CMD_MOVI) ? imm_q : c_q;

  dp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS)) u_regfile (
    .clk       (clk),
    .rst_n_i   (reset_n),
    .we_i      (wr_en),
    .waddr_i   (rd_q),
    .wdata_i   (wr_dat),
    .raddr_a_i (rn_q),
    .raddr_b_i (rm_q),
    .rdata_a_o (ra_dat),
    .rdata_b_o (rb_dat),
    .reg_out_o (bus.reg_out)
  );

  always_comb begin
    shift_dat = rb_dat;
    case (shift_q)
      SH_LSL1: shift_dat = {rb_dat[MSB-1:0], 1'b0};
      SH_LSR1: shift_dat = {1'b0, rb_dat[MSB:1]};
      SH_ASR1: shift_dat = {rb_dat[MSB], rb_dat[MSB:1]};
      default: shift_dat = rb_dat;
    endcase
  end

  assign eff_op = (cmd_op_q == CMD_MOVR) ? ALU_ADD : alu_op_q;

  // SUB is A + ~B + 1, so the carry-out is directly the not-borrow flag.
  always_comb begin
    sum_w   = '0;
    alu_dat = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (eff_op)
      ALU_ADD: begin
        sum_w   = {1'b0, a_q} + {1'b0, b_q};
        alu_dat = sum_w[MSB:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a_q[MSB] == b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      ALU_SUB: begin
        sum_w   = {1'b0, a_q} + {1'b0, ~b_q} + {{WIDTH{1'b0}}, 1'b1};
        alu_dat = sum_w[MSB:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (a_q[MSB] != b_q[MSB]) && (sum_w[MSB] != a_q[MSB]);
      end
      ALU_AND: alu_dat = a_q & b_q;
      ALU_MVN: alu_dat = ~b_q;
      default: alu_dat = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      cmd_op_q    <= CMD_REG;
      alu_op_q    <= ALU_ADD;
      shift_q     <= SH_NONE;
      rd_q        <= '0;
      rn_q        <= '0;
      rm_q        <= '0;
      imm_q       <= '0;
      wb_en_q     <= 1'b0;
      set_flags_q <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      status_q    <= 4'b0000;
      done_q      <= 1'b0;
      ready_q     <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: if (bus.cmd_valid) begin
          cmd_op_q    <= bus.cmd_op;
          alu_op_q    <= bus.alu_op;
          shift_q     <= bus.shift;
          rd_q        <= bus.rd;
          rn_q        <= bus.rn;
          rm_q        <= bus.rm;
          imm_q       <= bus.imm;
          wb_en_q     <= bus.wb_en;
          set_flags_q <= bus.set_flags;
          ready_q     <= 1'b0;
          case (bus.cmd_op)
            CMD_MOVR: begin
              a_q     <= '0;
              state_q <= S_RDB;
            end
            CMD_MOVI: begin
              state_q <= S_WB;
              done_q  <= 1'b1;
            end
            default:  state_q <= S_RDA;
          endcase
        end
        S_RDA: begin
          a_q <= ra_dat;
          if (cmd_op_q == CMD_IMM) begin
            b_q     <= imm_q;
            state_q <= S_EXEC;
          end else begin
            state_q <= S_RDB;
          end
        end
        S_RDB: begin
          b_q     <= shift_dat;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          c_q <= alu_dat;
          if (set_flags_q) begin
            status_q[FLAG_Z] <= (alu_dat == '0);
            status_q[FLAG_V] <= alu_v;
            status_q[FLAG_N] <= alu_dat[MSB];
            status_q[FLAG_C] <= alu_c;
          end
          state_q <= S_WB;
          done_q  <= 1'b1;
        end
        S_WB: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = ready_q;
  assign bus.done       = done_q;
  assign bus.result     = c_q;
  assign bus.status_out = status_q;

endmodule

// File: tb/tb_dp_seq_core.sv
// Directed bench for dp_seq_core: 16-bit/8-reg instance for the main sequence, 8-bit/4-reg instance for the carry-wrap case.
module tb_dp_seq_core;
  import dp_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  logic rst8_n;
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_r [8];

  always #5 clk = ~clk;

  dp_seq_core_if #(.WIDTH(16), .NREGS(8)) bus  ();
  dp_seq_core_if #(.WIDTH(8),  .NREGS(4)) bus8 ();

  dp_seq_core #(.WIDTH(16), .NREGS(8)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  dp_seq_core #(.WIDTH(8),  .NREGS(4)) dut8 (.clk(clk), .reset_n(rst8_n),  .bus(bus8));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] packed_regs();
    logic [127:0] r;
    for (int i = 0; i < 8; i++) r[i*16 +: 16] = exp_r[i];
    return r;
  endfunction

  // Called at a negedge with the core idle; returns at the negedge of the following idle cycle.
  task automatic issue(input cmd_op_t op, input alu_op_t aop, input shift_t sh,
                       input int rd_, input int rn_, input int rm_, input logic [15:0] im,
                       input logic wb, input logic sf, input int exp_lat, input string tag);
    int n;
    int lat;
    bus.cmd_op = op; bus.alu_op = aop; bus.shift = sh;
    bus.rd = rd_[2:0]; bus.rn = rn_[2:0]; bus.rm = rm_[2:0];
    bus.imm = im; bus.wb_en = wb; bus.set_flags = sf;
    bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk({tag, "_busy"}, bus.cmd_ready, 1'b0);
    lat = 1;
    while (!bus.done && lat < 20) begin @(negedge clk); lat++; end
    chk({tag, "_lat"}, lat, exp_lat);
    @(negedge clk);
  endtask

  task automatic movi(input int rd_, input logic [15:0] im);
    issue(CMD_MOVI, ALU_ADD, SH_NONE, rd_, 0, 0, im, 1'b1, 1'b0, 1, "movi");
    exp_r[rd_] = im;
  endtask

  task automatic issue8(input cmd_op_t op, input int rd_, input int rn_, input int rm_,
                        input logic [7:0] im, input logic sf);
    int n;
    bus8.cmd_op = op; bus8.alu_op = ALU_ADD; bus8.shift = SH_NONE;
    bus8.rd = rd_[1:0]; bus8.rn = rn_[1:0]; bus8.rm = rm_[1:0];
    bus8.imm = im; bus8.wb_en = 1'b1; bus8.set_flags = sf;
    bus8.cmd_valid = 1'b1;
    @(negedge clk);
    bus8.cmd_valid = 1'b0;
    n = 0;
    while (!bus8.cmd_ready && n < 20) begin @(negedge clk); n++; end
    chk("w8_idle", bus8.cmd_ready, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs;
    int dones;
    int hs_cyc [3];
    logic drop;

    for (int i = 0; i < 8; i++) exp_r[i] = '0;
    reset_n = 1'b0; rst8_n = 1'b0;
    bus.cmd_valid = 1'b0; bus.cmd_op = CMD_REG; bus.alu_op = ALU_ADD; bus.shift = SH_NONE;
    bus.rd = '0; bus.rn = '0; bus.rm = '0; bus.imm = '0; bus.wb_en = 1'b0; bus.set_flags = 1'b0;
    bus8.cmd_valid = 1'b0; bus8.cmd_op = CMD_REG; bus8.alu_op = ALU_ADD; bus8.shift = SH_NONE;
    bus8.rd = '0; bus8.rn = '0; bus8.rm = '0; bus8.imm = '0; bus8.wb_en = 1'b0; bus8.set_flags = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_ready",  bus.cmd_ready,  1'b1);
    chk("rst_done",   bus.done,       1'b0);
    chk("rst_status", bus.status_out, 4'b0000);
    chk("rst_result", bus.result,     16'h0000);
    chk("rst_regs",   bus.reg_out,    128'h0);
    reset_n = 1'b1; rst8_n = 1'b1;
    @(negedge clk);

    movi(1, 16'h0007);
    chk("movi_r1",     bus.reg_out, packed_regs());
    chk("movi_status", bus.status_out, 4'b0000);

    movi(2, 16'h0003);
    issue(CMD_REG, ALU_ADD, SH_LSL1, 3, 1, 2, 16'h0000, 1'b1, 1'b1, 4, "add_reg");
    exp_r[3] = 16'h000D;
    chk("add_regs",   bus.reg_out,    packed_regs());
    chk("add_result", bus.result,     16'h000D);
    chk("add_status", bus.status_out, 4'b0000);

    movi(1, 16'h7FFF);
    movi(2, 16'hFFFF);
    issue(CMD_IMM, ALU_SUB, SH_LSL1, 6, 1, 2, 16'hFFFF, 1'b0, 1'b1, 3, "cmp");
    chk("cmp_status", bus.status_out, 4'b0110);
    chk("cmp_result", bus.result,     16'h8000);
    chk("cmp_regs",   bus.reg_out,    packed_regs());

    movi(4, 16'h8002);
    issue(CMD_MOVR, ALU_SUB, SH_ASR1, 5, 1, 4, 16'h0000, 1'b1, 1'b0, 3, "movr_asr");
    exp_r[5] = 16'hC001;
    chk("movr_asr_regs", bus.reg_out, packed_regs());
    issue(CMD_MOVR, ALU_AND, SH_LSR1, 6, 1, 4, 16'h0000, 1'b1, 1'b0, 3, "movr_lsr");
    exp_r[6] = 16'h4001;
    chk("movr_lsr_regs",   bus.reg_out,    packed_regs());
    chk("movr_lsr_result", bus.result,     16'h4001);
    chk("movr_status",     bus.status_out, 4'b0110);

    // Three IMM increments of R7 with cmd_valid held high throughout.
    bus.cmd_op = CMD_IMM; bus.alu_op = ALU_ADD; bus.shift = SH_NONE;
    bus.rd = 3'd7; bus.rn = 3'd7; bus.rm = 3'd0; bus.imm = 16'h0001;
    bus.wb_en = 1'b1; bus.set_flags = 1'b0; bus.cmd_valid = 1'b1;
    hs = 0; dones = 0; drop = 1'b0;
    for (int cyc = 0; cyc < 18; cyc++) begin
      if (bus.done) dones++;
      if (bus.cmd_ready && bus.cmd_valid) begin
        if (hs < 3) hs_cyc[hs] = cyc;
        hs++;
        if (hs == 3) drop = 1'b1;
      end
      @(negedge clk);
      if (drop) bus.cmd_valid = 1'b0;
    end
    exp_r[7] = 16'h0003;
    chk("stream_hs",    hs,    3);
    chk("stream_done",  dones, 3);
    chk("stream_gap1",  hs_cyc[1] - hs_cyc[0], 4);
    chk("stream_gap2",  hs_cyc[2] - hs_cyc[1], 4);
    chk("stream_regs",  bus.reg_out, packed_regs());

    // Abort an IMM ADD that would write 0x1234 to R5, while it sits in EXEC.
    bus.cmd_op = CMD_IMM; bus.alu_op = ALU_ADD; bus.rd = 3'd5; bus.rn = 3'd0;
    bus.imm = 16'h1234; bus.wb_en = 1'b1; bus.set_flags = 1'b1; bus.cmd_valid = 1'b1;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_regs",   bus.reg_out,    128'h0);
    chk("abort_ready",  bus.cmd_ready,  1'b1);
    chk("abort_status", bus.status_out, 4'b0000);
    dones = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    reset_n = 1'b1;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    chk("abort_no_done", dones, 0);
    chk("abort_r5",      bus.reg_out[80 +: 16], 16'h0000);

    issue8(CMD_MOVI, 1, 0, 0, 8'hFF, 1'b0);
    issue8(CMD_MOVI, 2, 0, 0, 8'h01, 1'b0);
    issue8(CMD_REG,  3, 1, 2, 8'h00, 1'b1);
    chk("w8_result", bus8.result,     8'h00);
    chk("w8_status", bus8.status_out, 4'b1001);
    chk("w8_regs",   bus8.reg_out,    32'h0001_FF00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
